hack_ctrl_seq: RTL

//  Multi-cycle control sequencer sitting directly upstream of ALUp1: fetches Hack

---
 rtl/hack_pkg.sv | 28 ++
 rtl/hack_jump_eval.sv | 19 +
 rtl/hack_ctrl_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack control sequencer: FSM states and
// instruction-word field positions.
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_t;

    localparam int CI_BIT  = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JLT     = 2;
    localparam int JEQ     = 1;
    localparam int JGT     = 0;

    function automatic logic [5:0] comp_bits(input logic [15:0] ir);
        return ir[COMP_HI:COMP_LO];
    endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Flag generation and jump decision from the ALU result and the three
// jump bits of a C-instruction.
module hack_jump_eval
    import hack_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    jmp,
    output logic          zr,
    output logic          ng,
    output logic          taken
);

    assign zr    = (alu_out == '0);
    assign ng    = alu_out[DW-1];
    assign taken = (jmp[JLT] & ng) | (jmp[JEQ] & zr) | (jmp[JGT] & ~zr & ~ng);

endmodule

// File: rtl/hack_ctrl_seq.sv
// Multi-cycle Hack sequencer: fetches and decodes instructions, drives an
// external ALU, and owns the A, D and PC registers.
module hack_ctrl_seq
    import hack_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_data,
    output logic          dmem_rd,
    output logic          dmem_wr,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic [DW-1:0] X,
    output logic [DW-1:0] Y,
    output logic          zx,
    output logic          nx,
    output logic          zy,
    output logic          ny,
    output logic          f,
    output logic          no,
    input  logic [DW-1:0] ALU_OUT,
    output logic          retire
);

    state_t        state_reg;
    logic [AW-1:0] pc_reg;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] ir_reg;
    logic [DW-1:0] mdr_reg;
    logic [DW-1:0] res_reg;
    logic [AW-1:0] waddr_reg;
    logic          imem_req_reg;
    logic          dmem_rd_reg;
    logic          dmem_wr_reg;
    logic          retire_reg;
    logic [5:0]    alu_ctrl_reg;

    logic zr;
    logic ng;
    logic taken;
    logic unused_flags;

    hack_jump_eval #(.DW(DW)) u_jump (
        .alu_out (ALU_OUT),
        .jmp     (ir_reg[JLT:JGT]),
        .zr      (zr),
        .ng      (ng),
        .taken   (taken)
    );

    // The flags only matter through the jump decision.
    assign unused_flags = zr ^ ng;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH;
            pc_reg       <= '0;
            a_reg        <= '0;
            d_reg        <= '0;
            ir_reg       <= '0;
            mdr_reg      <= '0;
            res_reg      <= '0;
            waddr_reg    <= '0;
            imem_req_reg <= 1'b0;
            dmem_rd_reg  <= 1'b0;
            dmem_wr_reg  <= 1'b0;
            retire_reg   <= 1'b0;
            alu_ctrl_reg <= '0;
        end else begin
            retire_reg  <= 1'b0;
            dmem_wr_reg <= 1'b0;
            case (state_reg)
                FETCH: begin
                    // A valid only counts once the request is actually on the bus.
                    if (imem_req_reg && imem_valid) begin
                        ir_reg       <= imem_data;
                        imem_req_reg <= 1'b0;
                        state_reg    <= DECODE;
                    end else begin
                        imem_req_reg <= 1'b1;
                    end
                end
                DECODE: begin
                    if (!ir_reg[CI_BIT]) begin
                        a_reg        <= ir_reg;
                        pc_reg       <= pc_reg + AW'(1);
                        retire_reg   <= 1'b1;
                        imem_req_reg <= 1'b1;
                        state_reg    <= FETCH;
                    end else if (ir_reg[A_BIT]) begin
                        dmem_rd_reg <= 1'b1;
                        state_reg   <= MEMRD;
                    end else begin
                        alu_ctrl_reg <= comp_bits(ir_reg);
                        state_reg    <= EXEC;
                    end
                end
                MEMRD: begin
                    if (dmem_rd_reg && dmem_rvalid) begin
                        mdr_reg      <= dmem_rdata;
                        dmem_rd_reg  <= 1'b0;
                        alu_ctrl_reg <= comp_bits(ir_reg);
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    // Jump target and store address both use A as it was before writeback.
                    alu_ctrl_reg <= '0;
                    waddr_reg    <= a_reg[AW-1:0];
                    pc_reg       <= taken ? a_reg[AW-1:0] : pc_reg + AW'(1);
                    res_reg      <= ALU_OUT;
                    if (ir_reg[DEST_A]) begin
                        a_reg <= ALU_OUT;
                    end
                    if (ir_reg[DEST_D]) begin
                        d_reg <= ALU_OUT;
                    end
                    if (ir_reg[DEST_M]) begin
                        dmem_wr_reg <= 1'b1;
                        state_reg   <= WRITE;
                    end else begin
                        retire_reg   <= 1'b1;
                        imem_req_reg <= 1'b1;
                        state_reg    <= FETCH;
                    end
                end
                WRITE: begin
                    retire_reg   <= 1'b1;
                    imem_req_reg <= 1'b1;
                    state_reg    <= FETCH;
                end
                default: begin
                    imem_req_reg <= 1'b0;
                    dmem_rd_reg  <= 1'b0;
                    alu_ctrl_reg <= '0;
                    state_reg    <= FETCH;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign dmem_rd    = dmem_rd_reg;
    assign dmem_wr    = dmem_wr_reg;
    assign dmem_addr  = (state_reg == WRITE) ? waddr_reg : a_reg[AW-1:0];
    assign dmem_wdata = res_reg;
    assign retire     = retire_reg;
    assign X          = d_reg;
    assign Y          = (ir_reg[CI_BIT] && ir_reg[A_BIT]) ? mdr_reg : a_reg;
    assign {zx, nx, zy, ny, f, no} = alu_ctrl_reg;

endmodule
